spi_slave_rx: RTL and testbench

SPI mode-0 slave byte receiver that sits directly upstream of the command decoder. It oversamples the external SPI pins in the system clock domain and assembles MSB-first bytes. For each completed byte it presents `command_byte` with a one-cycle `byte_ready` strobe, the exact pair the decoder consumes. It can optionally echo the previously received byte back on MISO.

---
 rtl/spi_slave_rx.sv | 179 +++++++++++++++++
 tb/tb_spi_slave_rx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI mode-0 slave byte receiver.
// Oversamples sclk/mosi/cs_n in the clk domain, assembles MSB-first bytes and
// presents each completed byte on command_byte with a one-cycle byte_ready.
// Optional feature macro: SPI_ECHO_EN -- when defined, miso shifts out the
// previously completed byte during each byte slot; when undefined, miso is 0.
module spi_slave_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  output logic [7:0] command_byte,
  output logic       byte_ready,
  output logic       busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Synchronizer chains; the last stage is the synchronized value.
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  // Marks chain stages that hold a real pin sample rather than a reset value.
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   sclk_hist_q;
  logic                   cs_hist_q;

  logic sclk_s;
  logic mosi_s;
  logic cs_s;
  logic sclk_rise;
  logic cs_fall;

  state_t      state_q;
  logic        busy_q;
  logic        arm_q;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;
  logic [7:0]  rx_shift_q;
  logic [7:0]  rx_shift_d;
  logic [7:0]  cmd_q;
  logic        br_q;

`ifdef SPI_ECHO_EN
  logic        sclk_fall;
  logic [7:0]  tx_shift_q;
  logic [7:0]  echo_q;
  logic        miso_q;
`endif

  // Synchronize the SPI pins and keep one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      fill_q      <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign cs_fall   = cs_hist_q & ~cs_s;
`ifdef SPI_ECHO_EN
  assign sclk_fall = ~sclk_s & sclk_hist_q;
`endif

  // Next shift-register contents and bit count on an sclk rising edge.
  always_comb begin
    rx_shift_d = {rx_shift_q[6:0], mosi_s};
    cnt_d      = cnt_q + 3'd1;
  end

  // Frame FSM: receive path, byte hand-off and optional echo transmit path.
  // arm_q only sets once a genuinely sampled cs_n high has been seen, so a
  // cs_n held low across reset release cannot start a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      arm_q      <= 1'b0;
      cnt_q      <= 3'd0;
      rx_shift_q <= 8'h00;
      cmd_q      <= 8'h00;
      br_q       <= 1'b0;
`ifdef SPI_ECHO_EN
      tx_shift_q <= 8'h00;
      echo_q     <= 8'h00;
      miso_q     <= 1'b0;
`endif
    end else begin
      br_q <= 1'b0;
      if (fill_q[SYNC_STAGES-1] && cs_s) begin
        arm_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (arm_q && cs_fall) begin
            state_q    <= ACTIVE;
            busy_q     <= 1'b1;
            cnt_q      <= 3'd0;
            rx_shift_q <= 8'h00;
`ifdef SPI_ECHO_EN
            tx_shift_q <= echo_q;
            miso_q     <= echo_q[7];
`endif
          end
        end
        ACTIVE: begin
          // A high synced cs_n ends the frame and overrides any same-cycle
          // sclk edge; a partial byte is dropped.
          if (cs_s) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            cnt_q      <= 3'd0;
            rx_shift_q <= 8'h00;
`ifdef SPI_ECHO_EN
            miso_q     <= 1'b0;
`endif
          end else begin
            if (sclk_rise) begin
              rx_shift_q <= rx_shift_d;
              cnt_q      <= cnt_d;
              if (cnt_q == 3'd7) begin
                cmd_q  <= rx_shift_d;
                br_q   <= 1'b1;
`ifdef SPI_ECHO_EN
                echo_q <= rx_shift_d;
`endif
              end
            end
`ifdef SPI_ECHO_EN
            else if (sclk_fall) begin
              if (cnt_q != 3'd0) begin
                tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                miso_q     <= tx_shift_q[6];
              end else begin
                tx_shift_q <= echo_q;
                miso_q     <= echo_q[7];
              end
            end
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign command_byte = cmd_q;
  assign byte_ready   = br_q;
  assign busy         = busy_q;
`ifdef SPI_ECHO_EN
  assign miso         = miso_q;
`else
  assign miso         = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed-vector bench for spi_slave_rx (clk/16 SCLK).
module tb_spi_slave_rx;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       miso;
  logic [7:0] command_byte;
  logic       byte_ready;
  logic       busy;

  int checks;
  int errors;
  int pulse_cnt;
  int wide_cnt;
  logic [7:0] pulse_val [0:63];
  logic prev_br;
  logic [7:0] miso_bits;

  spi_slave_rx #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclk         (sclk),
    .mosi         (mosi),
    .cs_n         (cs_n),
    .miso         (miso),
    .command_byte (command_byte),
    .byte_ready   (byte_ready),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor sampled on the inactive edge.
  initial begin
    pulse_cnt = 0;
    wide_cnt  = 0;
    prev_br   = 1'b0;
    forever begin
      @(negedge clk);
      if (byte_ready) begin
        if (pulse_cnt < 64) pulse_val[pulse_cnt] = command_byte;
        pulse_cnt = pulse_cnt + 1;
        if (prev_br) wide_cnt = wide_cnt + 1;
      end
      prev_br = byte_ready;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_start();
    cs_n = 1'b0;
    wait_clks(8);
  endtask

  task automatic frame_end();
    wait_clks(8);
    cs_n = 1'b1;
    wait_clks(12);
  endtask

  // Clock out nbits of b, MSB first; miso captured at each sclk rise.
  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      wait_clks(8);
      sclk = 1'b1;
      miso_bits = {miso_bits[6:0], miso};
      wait_clks(8);
      sclk = 1'b0;
    end
  endtask

  initial begin
    int base;
    logic [7:0] echo_exp;
    checks    = 0;
    errors    = 0;
    miso_bits = 8'h00;
    rst_n = 1'b0;
    sclk  = 1'b0;
    mosi  = 1'b0;
    cs_n  = 1'b1;
    wait_clks(4);
    check("rst_cmd", {24'h0, command_byte}, 32'h0);
    check("rst_br", {31'h0, byte_ready}, 32'h0);
    check("rst_miso", {31'h0, miso}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    wait_clks(100);
    check("idle_pulses", pulse_cnt, 0);
    check("idle_busy", {31'h0, busy}, 32'h0);

    // Single byte A5
    base = pulse_cnt;
    frame_start();
    check("a5_busy", {31'h0, busy}, 32'h1);
    send_bits(8'hA5, 8);
    frame_end();
    check("a5_pulses", pulse_cnt - base, 1);
    check("a5_val", {24'h0, pulse_val[base]}, 32'hA5);
    check("a5_held", {24'h0, command_byte}, 32'hA5);
    check("a5_busy_off", {31'h0, busy}, 32'h0);

    // Three back-to-back bytes
    base = pulse_cnt;
    frame_start();
    send_bits(8'h00, 8);
    send_bits(8'h3F, 8);
    send_bits(8'hFF, 8);
    frame_end();
    check("m3_pulses", pulse_cnt - base, 3);
    check("m3_b0", {24'h0, pulse_val[base]}, 32'h00);
    check("m3_b1", {24'h0, pulse_val[base+1]}, 32'h3F);
    check("m3_b2", {24'h0, pulse_val[base+2]}, 32'hFF);
    check("m3_width", wide_cnt, 0);

    // Aborted partial byte, then a clean 01
    base = pulse_cnt;
    frame_start();
    send_bits(8'h12, 5);
    frame_end();
    check("abort_pulses", pulse_cnt - base, 0);
    check("abort_held", {24'h0, command_byte}, 32'hFF);
    frame_start();
    send_bits(8'h01, 8);
    frame_end();
    check("after_abort_pulses", pulse_cnt - base, 1);
    check("after_abort_val", {24'h0, pulse_val[base]}, 32'h01);

    // Echo: second byte of the frame carries the first one back
    base = pulse_cnt;
    frame_start();
    send_bits(8'hC3, 8);
    miso_bits = 8'h00;
    send_bits(8'h5A, 8);
    frame_end();
`ifdef SPI_ECHO_EN
    echo_exp = 8'hC3;
`else
    echo_exp = 8'h00;
`endif
    check("echo_miso", {24'h0, miso_bits}, {24'h0, echo_exp});
    check("echo_rx", {24'h0, pulse_val[base+1]}, 32'h5A);

    // Reset mid-byte with cs_n still low at release
    base = pulse_cnt;
    frame_start();
    send_bits(8'hF0, 4);
    rst_n = 1'b0;
    wait_clks(3);
    check("mid_rst_cmd", {24'h0, command_byte}, 32'h0);
    rst_n = 1'b1;
    wait_clks(8);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    send_bits(8'hF0, 4);
    send_bits(8'hAA, 8);
    frame_end();
    check("mid_rst_pulses", pulse_cnt - base, 0);
    check("mid_rst_held", {24'h0, command_byte}, 32'h0);
    frame_start();
    send_bits(8'h7E, 8);
    frame_end();
    check("post_rst_pulses", pulse_cnt - base, 1);
    check("post_rst_val", {24'h0, command_byte}, 32'h7E);
    check("final_width", wide_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
